pulse_width_monitor: RTL and testbench

PULSE_WIDTH_MONITOR -- requirements
Module: pulse_width_monitor

---
 rtl/pulse_width_monitor.sv | 172 +++++++++++++++++
 tb/tb_pulse_width_monitor.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_width_monitor.sv
// pulse_width_monitor
//
// Watches NUM_CH single-bit inputs for high runs that are too short
// (fewer than MIN_HIGH samples) or too long (more than MAX_HIGH samples;
// MAX_HIGH = 0 disables the long check). Each violation produces a
// one-cycle pulse, bumps a saturating per-channel counter and sets a
// sticky flag. Counters are read through a level request / one-cycle
// acknowledge handshake.
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous reset, active-high (name kept for compatibility)
//   en         monitor enable; 0 freezes run tracking
//   din        monitored bits
//   clr        synchronous clear of counters, sticky flags and run state
//   rd_req     counter read request, held until rd_ack
//   rd_ch      channel to read
//   rd_ack     one-cycle read acknowledge
//   rd_data    violation count captured for rd_ch (0 if rd_ch >= NUM_CH)
//   viol_short one-cycle pulse per short-run violation
//   viol_long  one-cycle pulse per long-run violation
//   sticky     latched per-channel violation flag
//   any_viol   OR of sticky
module pulse_width_monitor #(
    parameter int NUM_CH   = 16,
    parameter int MIN_HIGH = 5,
    parameter int MAX_HIGH = 0,
    parameter int RUN_W    = 8,
    parameter int CNT_W    = 16,
    localparam int RD_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [NUM_CH-1:0] din,
    input  logic              clr,
    input  logic              rd_req,
    input  logic [RD_W-1:0]   rd_ch,
    output logic              rd_ack,
    output logic [CNT_W-1:0]  rd_data,
    output logic [NUM_CH-1:0] viol_short,
    output logic [NUM_CH-1:0] viol_long,
    output logic [NUM_CH-1:0] sticky,
    output logic              any_viol
);

    localparam logic [RUN_W-1:0] MIN_R   = RUN_W'(MIN_HIGH);
    localparam logic [RUN_W-1:0] MAX_R   = RUN_W'(MAX_HIGH);
    localparam bit               LONG_EN = (MAX_HIGH != 0);

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_ACK  = 2'd1,
        RD_HOLD = 2'd2
    } rd_state_t;

    function automatic logic [RUN_W-1:0] run_inc_sat(input logic [RUN_W-1:0] r);
        return (&r) ? r : r + RUN_W'(1);
    endfunction

    function automatic logic [CNT_W-1:0] cnt_inc_sat(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    logic [NUM_CH-1:0] prev_p0;
    logic [RUN_W-1:0]  run_p0 [NUM_CH];
    logic [NUM_CH-1:0] short_det_p0;
    logic [NUM_CH-1:0] long_det_p0;
    logic [CNT_W-1:0]  cnt_p1 [NUM_CH];
    rd_state_t         rd_state;
    rd_state_t         rd_state_nxt;
    logic [31:0]       rd_idx;
    logic [CNT_W-1:0]  rd_sel;

    // ---- stage p0: edge detection against the tracked run ----
    // A long-flagged run has run > MAX_HIGH >= MIN_HIGH at its fall, so it
    // can never also qualify as short. run == MAX_HIGH is passed exactly
    // once per run because run keeps counting up (and saturates above it).
    always_comb begin
        short_det_p0 = '0;
        long_det_p0  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            short_det_p0[i] = en && prev_p0[i] && !din[i] && (run_p0[i] < MIN_R);
            long_det_p0[i]  = LONG_EN && en && prev_p0[i] && din[i] && (run_p0[i] == MAX_R);
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            prev_p0 <= '0;
            for (int i = 0; i < NUM_CH; i++) run_p0[i] <= '0;
        end else if (clr) begin
            prev_p0 <= '0;
            for (int i = 0; i < NUM_CH; i++) run_p0[i] <= '0;
        end else if (en) begin
            prev_p0 <= din;
            for (int i = 0; i < NUM_CH; i++) begin
                case ({din[i], prev_p0[i]})
                    2'b10:   run_p0[i] <= RUN_W'(1);
                    2'b11:   run_p0[i] <= run_inc_sat(run_p0[i]);
                    2'b01:   run_p0[i] <= '0;
                    default: run_p0[i] <= run_p0[i];
                endcase
            end
        end
    end

    // ---- stage p1: violation pulses, counters, sticky flags ----
    // clr takes priority over a violation detected on the same edge.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            viol_short <= '0;
            viol_long  <= '0;
            sticky     <= '0;
            for (int i = 0; i < NUM_CH; i++) cnt_p1[i] <= '0;
        end else if (clr) begin
            viol_short <= '0;
            viol_long  <= '0;
            sticky     <= '0;
            for (int i = 0; i < NUM_CH; i++) cnt_p1[i] <= '0;
        end else begin
            viol_short <= short_det_p0;
            viol_long  <= long_det_p0;
            for (int i = 0; i < NUM_CH; i++) begin
                if (short_det_p0[i] || long_det_p0[i]) begin
                    cnt_p1[i] <= cnt_inc_sat(cnt_p1[i]);
                    sticky[i] <= 1'b1;
                end
            end
        end
    end

    assign any_viol = |sticky;

    // ---- read port: counter select, handshake FSM, captured data ----
    // Out-of-range channel numbers match no entry and read back as 0.
    assign rd_idx = 32'(rd_ch);

    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_idx == 32'(i)) rd_sel = cnt_p1[i];
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) rd_state <= RD_IDLE;
        else       rd_state <= rd_state_nxt;
    end

    always_comb begin
        rd_state_nxt = rd_state;
        case (rd_state)
            RD_IDLE: if (rd_req) rd_state_nxt = RD_ACK;
            RD_ACK:  rd_state_nxt = RD_HOLD;
            RD_HOLD: if (!rd_req) rd_state_nxt = RD_IDLE;
            default: rd_state_nxt = RD_IDLE;
        endcase
    end

    always_comb begin
        rd_ack = (rd_state == RD_ACK);
    end

    // Data is captured on the same edge that moves IDLE->ACK and then held
    // until the next request is accepted.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n)                             rd_data <= '0;
        else if (rd_state == RD_IDLE && rd_req) rd_data <= rd_sel;
    end

endmodule

// File: tb/tb_pulse_width_monitor.sv
// Scoreboard bench for pulse_width_monitor. Twelve channels are used so
// that the 4-bit rd_ch can express an out-of-range channel (13); CNT_W=2
// makes counter saturation reachable; MAX_HIGH=8 enables the long check.
module tb_pulse_width_monitor;

    localparam int NCH   = 12;
    localparam int MIN_H = 5;
    localparam int MAX_H = 8;
    localparam int CW    = 2;
    localparam int CMAX  = (1 << CW) - 1;

    localparam int K_SHORT = 0;
    localparam int K_LONG  = 1;
    localparam int K_READ  = 2;

    logic           clk    = 1'b0;
    logic           rst_n  = 1'b1;
    logic           en     = 1'b0;
    logic           clr    = 1'b0;
    logic           rd_req = 1'b0;
    logic [NCH-1:0] din    = '0;
    logic [3:0]     rd_ch  = '0;
    logic           rd_ack;
    logic [CW-1:0]  rd_data;
    logic [NCH-1:0] viol_short;
    logic [NCH-1:0] viol_long;
    logic [NCH-1:0] sticky;
    logic           any_viol;

    always #5 clk = ~clk;

    pulse_width_monitor #(
        .NUM_CH  (NCH),
        .MIN_HIGH(MIN_H),
        .MAX_HIGH(MAX_H),
        .RUN_W   (8),
        .CNT_W   (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .din       (din),
        .clr       (clr),
        .rd_req    (rd_req),
        .rd_ch     (rd_ch),
        .rd_ack    (rd_ack),
        .rd_data   (rd_data),
        .viol_short(viol_short),
        .viol_long (viol_long),
        .sticky    (sticky),
        .any_viol  (any_viol)
    );

    typedef struct {
        int kind;
        int ch;
        int data;
        int cyc;
    } ev_t;

    ev_t            sb[$];
    int             vectors     = 0;
    int             miscompares = 0;
    int             cyc         = 0;
    int             exp_cnt[NCH];
    logic [NCH-1:0] exp_sticky  = '0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(input int kind);
        case (kind)
            K_SHORT: return "viol_short";
            K_LONG:  return "viol_long";
            default: return "rd_ack";
        endcase
    endfunction

    // Monitor: every output event must match a queued expectation for the
    // current cycle; expectations left behind are reported as missing.
    task automatic sb_match(input int kind, input int ch, input int data);
        int hit = -1;
        for (int j = 0; j < sb.size(); j++) begin
            if (hit < 0 && sb[j].kind == kind && sb[j].cyc == cyc &&
                (kind == K_READ || sb[j].ch == ch))
                hit = j;
        end
        vectors++;
        if (hit < 0) begin
            miscompares++;
            $display("FAIL unexpected_%s ch=%0d cyc=%0d: got event, required none",
                     kname(kind), ch, cyc);
        end else begin
            if (kind == K_READ && data != sb[hit].data) begin
                miscompares++;
                $display("FAIL rd_data ch=%0d cyc=%0d: got %0d, required %0d",
                         sb[hit].ch, cyc, data, sb[hit].data);
            end
            sb.delete(hit);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (viol_short[i]) sb_match(K_SHORT, i, 0);
            if (viol_long[i])  sb_match(K_LONG, i, 0);
        end
        if (rd_ack) sb_match(K_READ, -1, int'(rd_data));
        for (int j = sb.size() - 1; j >= 0; j--) begin
            if (sb[j].cyc < cyc) begin
                vectors++;
                miscompares++;
                $display("FAIL missing_%s ch=%0d: got nothing at cyc %0d, required event",
                         kname(sb[j].kind), sb[j].ch, sb[j].cyc);
                sb.delete(j);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 'h%0h, required 'h%0h", name, act, req);
        end
    endtask

    // The input being driven now is sampled at the next edge; a violation
    // it causes is visible during the following cycle (cyc + 1).
    task automatic expect_viol(input int kind, input int ch);
        sb.push_back('{kind, ch, 0, cyc + 1});
        if (exp_cnt[ch] < CMAX) exp_cnt[ch]++;
        exp_sticky[ch] = 1'b1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < NCH; i++) exp_cnt[i] = 0;
        exp_sticky = '0;
    endtask

    // High run of len samples on every channel in mask, then one low sample.
    task automatic run_pulse(input logic [NCH-1:0] mask, input int len);
        for (int i = 0; i < len; i++) begin
            din = din | mask;
            if (i == MAX_H)
                for (int c = 0; c < NCH; c++) if (mask[c]) expect_viol(K_LONG, c);
            tick();
        end
        din = din & ~mask;
        if (len < MIN_H)
            for (int c = 0; c < NCH; c++) if (mask[c]) expect_viol(K_SHORT, c);
        tick();
    endtask

    task automatic do_read(input int ch, input int exp_v);
        rd_req = 1'b1;
        rd_ch  = 4'(ch);
        sb.push_back('{K_READ, ch, exp_v, cyc + 1});
        repeat (4) tick();
        rd_req = 1'b0;
        repeat (2) tick();
    endtask

    initial begin
        clear_model();
        repeat (3) tick();
        @(negedge clk);
        check("rst_viol_short", 32'(viol_short), 0);
        check("rst_viol_long", 32'(viol_long), 0);
        check("rst_sticky", 32'(sticky), 0);
        check("rst_any_viol", 32'(any_viol), 0);
        check("rst_rd_ack", 32'(rd_ack), 0);
        check("rst_rd_data", 32'(rd_data), 0);
        tick();
        rst_n = 1'b0;
        en    = 1'b1;
        tick();

        // exactly MIN_HIGH is legal, one less is short
        run_pulse(NCH'(1) << 3, 5);
        do_read(3, 0);
        run_pulse(NCH'(1) << 3, 4);
        do_read(3, exp_cnt[3]);

        // short run on ch0, sticky and any_viol follow
        run_pulse(NCH'(1) << 0, 2);
        @(negedge clk);
        check("sticky_ch0", 32'(sticky), 32'(exp_sticky));
        check("any_viol_set", 32'(any_viol), 1);
        tick();
        do_read(0, exp_cnt[0]);

        // long runs: 20 samples flags once, exactly MAX_HIGH is legal, MAX_HIGH+1 flags
        run_pulse(NCH'(1) << 7, 20);
        do_read(7, exp_cnt[7]);
        run_pulse(NCH'(1) << 11, 8);
        run_pulse(NCH'(1) << 11, 9);
        do_read(11, exp_cnt[11]);

        // two channels violating in the same cycle
        run_pulse(NCH'(12'h300), 3);
        do_read(8, exp_cnt[8]);
        do_read(9, exp_cnt[9]);

        // pulse already registered still appears after en drops
        din[4] = 1'b1;
        repeat (2) tick();
        din[4] = 1'b0;
        expect_viol(K_SHORT, 4);
        tick();
        en = 1'b0;
        repeat (2) tick();
        en = 1'b1;
        tick();
        do_read(4, exp_cnt[4]);

        // short pulse while disabled is ignored
        en     = 1'b0;
        din[6] = 1'b1;
        repeat (2) tick();
        din[6] = 1'b0;
        tick();
        en = 1'b1;
        tick();
        do_read(6, 0);
        @(negedge clk);
        check("sticky_en_off", 32'(sticky), 32'(exp_sticky));
        tick();

        // read hold, single ack, held data, out-of-range channel
        repeat (3) run_pulse(NCH'(1) << 2, 2);
        do_read(2, 3);
        @(negedge clk);
        check("rd_data_held", 32'(rd_data), 3);
        tick();
        do_read(13, 0);

        // counter saturation at 2^CNT_W-1
        repeat (5) run_pulse(NCH'(1) << 5, 1);
        do_read(5, CMAX);

        // clr on the edge that would register ch1's violation
        din[1] = 1'b1;
        repeat (2) tick();
        din[1] = 1'b0;
        clr    = 1'b1;
        tick();
        clr = 1'b0;
        clear_model();
        @(negedge clk);
        check("clr_sticky", 32'(sticky), 0);
        check("clr_any_viol", 32'(any_viol), 0);
        tick();
        do_read(1, 0);
        do_read(2, 0);

        // reset mid-run; din high at release starts a fresh run
        run_pulse(NCH'(1) << 0, 2);
        din[10] = 1'b1;
        repeat (2) tick();
        rst_n = 1'b1;
        clear_model();
        @(negedge clk);
        check("midrst_sticky", 32'(sticky), 0);
        check("midrst_viol_short", 32'(viol_short), 0);
        tick();
        rst_n = 1'b0;
        repeat (2) tick();
        din[10] = 1'b0;
        expect_viol(K_SHORT, 10);
        tick();
        tick();
        do_read(10, exp_cnt[10]);
        do_read(0, 0);

        repeat (5) tick();
        foreach (sb[j]) begin
            vectors++;
            miscompares++;
            $display("FAIL leftover_%s ch=%0d: got nothing, required event at cyc %0d",
                     kname(sb[j].kind), sb[j].ch, sb[j].cyc);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
